galois_lfsr_checker: RTL and testbench

- Receive end of the LFSR/FIFO test path: consumes the pseudo-random nibble stream produced by the team's parallel Galois LFSR (e.g. FIFO pop output) and verifies it against a local reference LFSR.
- Hunts for the seed nibble, verifies lock, then counts matches and errors, and reports loss of lock. Status drives board LEDs.

---
 rtl/galois_lfsr_pkg.sv | 31 +++
 rtl/galois_lfsr_model.sv | 35 +++
 rtl/galois_lfsr_checker.sv | 196 +++++++++++++++++++
 tb/tb_galois_lfsr_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/galois_lfsr_pkg.sv
// Shared definitions for the Galois LFSR generator/checker pair. Both ends take
// their polynomial, seed and step function from here, so they cannot disagree.
package galois_lfsr_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } checker_state_t;

    localparam int         LFSR_MAX_WIDTH     = 32;
    localparam int         LFSR_DEFAULT_WIDTH = 8;
    localparam int         LFSR_DEFAULT_BPC   = 4;
    localparam logic [7:0] LFSR_DEFAULT_POLY  = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT_SEED  = 8'h01;

    typedef struct packed {
        logic [LFSR_MAX_WIDTH-1:0] next_state;
        logic                      out_bit;
    } lfsr_step_t;

    // Single right-shift Galois step; narrower LFSRs are zero-extended into the window.
    function automatic lfsr_step_t lfsr_step(input logic [LFSR_MAX_WIDTH-1:0] state,
                                             input logic [LFSR_MAX_WIDTH-1:0] mask);
        lfsr_step_t res;
        res.out_bit    = state[0];
        res.next_state = (state >> 1) ^ (state[0] ? mask : {LFSR_MAX_WIDTH{1'b0}});
        return res;
    endfunction

endpackage

// File: rtl/galois_lfsr_model.sv
// Combinational multi-step Galois LFSR: the word emitted from a given state and
// the state reached after BITS_PER_CLOCK steps. Shared by generator and checker.
module galois_lfsr_model
    import galois_lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH     = LFSR_DEFAULT_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY_MASK = LFSR_DEFAULT_POLY,
    parameter int                    BITS_PER_CLOCK = LFSR_DEFAULT_BPC
) (
    input  logic [LFSR_WIDTH-1:0]     state_in,
    output logic [BITS_PER_CLOCK-1:0] expected_word,
    output logic [LFSR_WIDTH-1:0]     next_state
);

    logic [LFSR_MAX_WIDTH-1:0] mask_s;
    logic [LFSR_MAX_WIDTH-1:0] walk_s;
    lfsr_step_t                step_s;

    // Unrolled chain of single steps; bit i of the word comes from step i.
    always_comb begin
        mask_s                   = {LFSR_MAX_WIDTH{1'b0}};
        mask_s[LFSR_WIDTH-1:0]   = LFSR_POLY_MASK;
        walk_s                   = {LFSR_MAX_WIDTH{1'b0}};
        walk_s[LFSR_WIDTH-1:0]   = state_in;
        step_s                   = '0;
        expected_word            = {BITS_PER_CLOCK{1'b0}};
        for (int i = 0; i < BITS_PER_CLOCK; i++) begin
            step_s           = lfsr_step(walk_s, mask_s);
            expected_word[i] = step_s.out_bit;
            walk_s           = step_s.next_state;
        end
        next_state = walk_s[LFSR_WIDTH-1:0];
    end

endmodule

// File: rtl/galois_lfsr_checker.sv
// Receive-side LFSR stream checker: hunts for the seed word, verifies lock over
// LOCK_COUNT words, then counts matches/errors and drops lock after LOSS_COUNT misses.
module galois_lfsr_checker
    import galois_lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH     = LFSR_DEFAULT_WIDTH,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED      = LFSR_DEFAULT_SEED,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY_MASK = LFSR_DEFAULT_POLY,
    parameter int                    BITS_PER_CLOCK = LFSR_DEFAULT_BPC,
    parameter int                    LOCK_COUNT     = 4,
    parameter int                    LOSS_COUNT     = 3,
    parameter int                    CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      data_valid,
    input  logic [BITS_PER_CLOCK-1:0] data_in,
    output logic                      locked,
    output logic                      lock_lost,
    output logic                      error_pulse,
    output logic [CNT_WIDTH-1:0]      match_count,
    output logic [CNT_WIDTH-1:0]      error_count
);

    localparam int                RUN_W        = $clog2(LOCK_COUNT + 1);
    localparam int                MISS_W       = $clog2(LOSS_COUNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_CNT_C   = RUN_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] LOSS_CNT_C   = MISS_W'(LOSS_COUNT);
    localparam logic              LOCK_ON_SEED = (LOCK_COUNT == 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX_C = {CNT_WIDTH{1'b1}};

    if (LOCK_COUNT < 1) begin : g_lock_count_check
        $fatal(1, "galois_lfsr_checker: LOCK_COUNT must be >= 1");
    end
    if (LOSS_COUNT < 1) begin : g_loss_count_check
        $fatal(1, "galois_lfsr_checker: LOSS_COUNT must be >= 1");
    end

    checker_state_t            state_q, state_d;
    logic [LFSR_WIDTH-1:0]     ref_q, ref_d;
    logic [RUN_W-1:0]          run_cnt_q, run_cnt_d;
    logic [MISS_W-1:0]         miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0]      match_count_q, match_count_d;
    logic [CNT_WIDTH-1:0]      error_count_q, error_count_d;
    logic                      locked_q, locked_d;
    logic                      lock_lost_q, lock_lost_d;
    logic                      error_pulse_q, error_pulse_d;

    logic [BITS_PER_CLOCK-1:0] exp_word_s;
    logic [LFSR_WIDTH-1:0]     ref_next_s;
    logic                      word_match_s;
    logic [RUN_W-1:0]          run_inc_s;
    logic [MISS_W-1:0]         miss_inc_s;

    // In HUNT ref_q sits at the seed, so this also yields the seed word.
    galois_lfsr_model #(
        .LFSR_WIDTH     (LFSR_WIDTH),
        .LFSR_POLY_MASK (LFSR_POLY_MASK),
        .BITS_PER_CLOCK (BITS_PER_CLOCK)
    ) u_ref_model (
        .state_in      (ref_q),
        .expected_word (exp_word_s),
        .next_state    (ref_next_s)
    );

    // Next-state, reference and counter update; clear outranks a valid word.
    always_comb begin
        state_d       = state_q;
        ref_d         = ref_q;
        run_cnt_d     = run_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        match_count_d = match_count_q;
        error_count_d = error_count_q;
        locked_d      = locked_q;
        lock_lost_d   = lock_lost_q;
        error_pulse_d = 1'b0;
        word_match_s  = (data_in == exp_word_s);
        run_inc_s     = run_cnt_q + RUN_W'(1);
        miss_inc_s    = miss_cnt_q + MISS_W'(1);

        if (clear) begin
            state_d       = HUNT;
            ref_d         = LFSR_SEED;
            run_cnt_d     = {RUN_W{1'b0}};
            miss_cnt_d    = {MISS_W{1'b0}};
            match_count_d = {CNT_WIDTH{1'b0}};
            error_count_d = {CNT_WIDTH{1'b0}};
            locked_d      = 1'b0;
            lock_lost_d   = 1'b0;
        end else if (data_valid) begin
            case (state_q)
                HUNT: begin
                    if (word_match_s) begin
                        ref_d     = ref_next_s;
                        run_cnt_d = RUN_W'(1);
                        if (LOCK_ON_SEED) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end else begin
                        ref_d = LFSR_SEED;
                    end
                end
                VERIFY: begin
                    if (word_match_s) begin
                        ref_d     = ref_next_s;
                        run_cnt_d = run_inc_s;
                        if (run_inc_s == LOCK_CNT_C) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d = VERIFY;
                        end
                    end else begin
                        ref_d     = LFSR_SEED;
                        run_cnt_d = {RUN_W{1'b0}};
                        state_d   = HUNT;
                    end
                end
                LOCKED: begin
                    // Reference keeps running through errors so isolated bit hits do not desync.
                    ref_d = ref_next_s;
                    if (word_match_s) begin
                        miss_cnt_d = {MISS_W{1'b0}};
                        if (match_count_q != CNT_MAX_C) begin
                            match_count_d = match_count_q + CNT_WIDTH'(1);
                        end else begin
                            match_count_d = match_count_q;
                        end
                    end else begin
                        error_pulse_d = 1'b1;
                        miss_cnt_d    = miss_inc_s;
                        if (error_count_q != CNT_MAX_C) begin
                            error_count_d = error_count_q + CNT_WIDTH'(1);
                        end else begin
                            error_count_d = error_count_q;
                        end
                        if (miss_inc_s == LOSS_CNT_C) begin
                            state_d     = HUNT;
                            locked_d    = 1'b0;
                            lock_lost_d = 1'b1;
                            ref_d       = LFSR_SEED;
                            miss_cnt_d  = {MISS_W{1'b0}};
                        end else begin
                            state_d = LOCKED;
                        end
                    end
                end
                default: begin
                    state_d    = HUNT;
                    ref_d      = LFSR_SEED;
                    run_cnt_d  = {RUN_W{1'b0}};
                    miss_cnt_d = {MISS_W{1'b0}};
                    locked_d   = 1'b0;
                end
            endcase
        end else begin
            error_pulse_d = 1'b0;
        end
    end

    // State, reference and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            ref_q         <= LFSR_SEED;
            run_cnt_q     <= {RUN_W{1'b0}};
            miss_cnt_q    <= {MISS_W{1'b0}};
            match_count_q <= {CNT_WIDTH{1'b0}};
            error_count_q <= {CNT_WIDTH{1'b0}};
            locked_q      <= 1'b0;
            lock_lost_q   <= 1'b0;
            error_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_q         <= ref_d;
            run_cnt_q     <= run_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            match_count_q <= match_count_d;
            error_count_q <= error_count_d;
            locked_q      <= locked_d;
            lock_lost_q   <= lock_lost_d;
            error_pulse_q <= error_pulse_d;
        end
    end

    assign locked      = locked_q;
    assign lock_lost   = lock_lost_q;
    assign error_pulse = error_pulse_q;
    assign match_count = match_count_q;
    assign error_count = error_count_q;

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Bench for galois_lfsr_checker: vector table plus hand sequences for reference
// tracking, counter saturation and asynchronous reset.
module tb_galois_lfsr_checker;
    import galois_lfsr_pkg::*;

    localparam int CW = 4;

    typedef struct {
        logic           valid;
        logic           clr;
        logic [3:0]     data;
        checker_state_t st;
        logic           locked;
        logic           lost;
        logic           err;
        logic [CW-1:0]  mc;
        logic [CW-1:0]  ec;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          data_valid = 1'b0;
    logic [3:0]    data_in = 4'h0;
    logic          locked;
    logic          lock_lost;
    logic          error_pulse;
    logic [CW-1:0] match_count;
    logic [CW-1:0] error_count;

    int   tests_run = 0;
    int   tests_failed = 0;
    vec_t sb_q[$];
    vec_t tbl[$];
    logic [7:0] tb_state;

    galois_lfsr_checker #(.CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .error_pulse (error_pulse),
        .match_count (match_count),
        .error_count (error_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic c, input logic [3:0] d,
                                input checker_state_t s, input logic l, input logic lo,
                                input logic e, input int mc, input int ec);
        vec_t r;
        r.valid = v; r.clr = c; r.data = d; r.st = s; r.locked = l;
        r.lost = lo; r.err = e; r.mc = CW'(mc); r.ec = CW'(ec);
        return r;
    endfunction

    // Bit-serial reference generator: emits next word and advances tb_state.
    function automatic logic [3:0] next_word(inout logic [7:0] s);
        logic [3:0] w;
        logic       b;
        for (int i = 0; i < 4; i++) begin
            b    = s[0];
            w[i] = b;
            s    = {1'b0, s[7:1]};
            if (b) s = s ^ 8'hB8;
        end
        return w;
    endfunction

    task automatic compare(input string name, input vec_t e);
        tests_run++;
        if (locked !== e.locked || lock_lost !== e.lost || error_pulse !== e.err ||
            match_count !== e.mc || error_count !== e.ec || dut.state_q !== e.st) begin
            tests_failed++;
            $display("FAIL %s: got lk=%b lost=%b err=%b mc=%0d ec=%0d st=%0d, want lk=%b lost=%b err=%b mc=%0d ec=%0d st=%0d",
                     name, locked, lock_lost, error_pulse, match_count, error_count, dut.state_q,
                     e.locked, e.lost, e.err, e.mc, e.ec, e.st);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        vec_t e;
        @(negedge clk);
        data_valid = v.valid;
        clear      = v.clr;
        data_in    = v.data;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        clear      = 1'b0;
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            compare(name, e);
        end
    endtask

    task automatic check_ref(input string name, input logic [7:0] want);
        tests_run++;
        if (dut.ref_q !== want) begin
            tests_failed++;
            $display("FAIL %s: ref got %h want %h", name, dut.ref_q, want);
        end
    endtask

    initial begin
        vec_t v;
        logic [3:0] w;
        int mc;
        int ec;

        // Walk through hunt, gap in verify, lock, errors, loss, re-lock, clear.
        tbl.push_back(mk(1, 0, 4'h3, HUNT,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h3, HUNT,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h1, VERIFY, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h7, VERIFY, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 4'hF, VERIFY, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h4, VERIFY, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'hA, LOCKED, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h5, LOCKED, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 4'h3, LOCKED, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 4'h0, LOCKED, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 4'h3, LOCKED, 1, 0, 0, 2, 1));
        tbl.push_back(mk(1, 0, 4'h0, LOCKED, 1, 0, 1, 2, 2));
        tbl.push_back(mk(1, 0, 4'h0, LOCKED, 1, 0, 1, 2, 3));
        tbl.push_back(mk(1, 0, 4'h0, HUNT,   0, 1, 1, 2, 4));
        tbl.push_back(mk(1, 0, 4'h1, VERIFY, 0, 1, 0, 2, 4));
        tbl.push_back(mk(1, 0, 4'h2, HUNT,   0, 1, 0, 2, 4));
        tbl.push_back(mk(1, 0, 4'h1, VERIFY, 0, 1, 0, 2, 4));
        tbl.push_back(mk(1, 0, 4'h7, VERIFY, 0, 1, 0, 2, 4));
        tbl.push_back(mk(1, 0, 4'h4, VERIFY, 0, 1, 0, 2, 4));
        tbl.push_back(mk(1, 0, 4'hA, LOCKED, 1, 1, 0, 2, 4));
        tbl.push_back(mk(1, 0, 4'h3, LOCKED, 1, 1, 0, 3, 4));
        tbl.push_back(mk(1, 1, 4'h0, HUNT,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h0, HUNT,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 4'h1, VERIFY, 0, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        #1 compare("reset", mk(0, 0, 4'h0, HUNT, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("tbl%0d", i), tbl[i]);
        end

        // Reference register tracking through the seed sequence.
        apply("ref_clr", mk(0, 1, 4'h0, HUNT, 0, 0, 0, 0, 0));
        check_ref("ref_seed", 8'h01);
        apply("ref_w3a", mk(1, 0, 4'h3, HUNT, 0, 0, 0, 0, 0));
        apply("ref_w3b", mk(1, 0, 4'h3, HUNT, 0, 0, 0, 0, 0));
        check_ref("ref_hold", 8'h01);
        apply("ref_w1", mk(1, 0, 4'h1, VERIFY, 0, 0, 0, 0, 0));
        check_ref("ref_17", 8'h17);
        apply("ref_w7", mk(1, 0, 4'h7, VERIFY, 0, 0, 0, 0, 0));
        check_ref("ref_64", 8'h64);
        apply("ref_w4", mk(1, 0, 4'h4, VERIFY, 0, 0, 0, 0, 0));
        check_ref("ref_5a", 8'h5A);

        // Saturation of both counters using the bench's own generator.
        apply("sat_clr", mk(0, 1, 4'h0, HUNT, 0, 0, 0, 0, 0));
        tb_state = 8'h01;
        for (int n = 0; n < 4; n++) begin
            w = next_word(tb_state);
            apply($sformatf("sat_lock%0d", n),
                  mk(1, 0, w, (n < 3) ? VERIFY : LOCKED, (n == 3), 0, 0, 0, 0));
        end
        mc = 0;
        for (int n = 0; n < 20; n++) begin
            w = next_word(tb_state);
            if (mc < 15) mc++;
            apply($sformatf("sat_mc%0d", n), mk(1, 0, w, LOCKED, 1, 0, 0, mc, 0));
        end
        ec = 0;
        for (int n = 0; n < 27; n++) begin
            w = next_word(tb_state);
            if ((n % 3) != 2) begin
                w = w ^ 4'hF;
                if (ec < 15) ec++;
                v = mk(1, 0, w, LOCKED, 1, 0, 1, mc, ec);
            end else begin
                v = mk(1, 0, w, LOCKED, 1, 0, 0, mc, ec);
            end
            apply($sformatf("sat_ec%0d", n), v);
        end

        // Asynchronous reset between clock edges while locked.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 compare("arst_low", mk(0, 0, 4'h0, HUNT, 0, 0, 0, 0, 0));
        check_ref("arst_ref", 8'h01);
        @(negedge clk);
        #2 reset_n = 1'b1;
        tb_state = 8'h01;
        for (int n = 0; n < 4; n++) begin
            w = next_word(tb_state);
            apply($sformatf("arst_relock%0d", n),
                  mk(1, 0, w, (n < 3) ? VERIFY : LOCKED, (n == 3), 0, 0, 0, 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
